// File: rtl/i_bus_prefetch_pkg.sv
// Shared types and constants for the instruction-bus prefetch buffer.
// IBUS_PREFETCH_EN adds the PREFETCH state to the FSM encoding.
package i_bus_prefetch_pkg;

`ifdef IBUS_PREFETCH_EN
  typedef enum logic [1:0] {StIdle, StFetch, StRetry, StPrefetch} state_e;
`else
  typedef enum logic [1:0] {StIdle, StFetch, StRetry} state_e;
`endif

  localparam logic [7:0]   WB_SEL_WORD    = 8'h0f;
  localparam int unsigned  MaxW           = 128;
  localparam logic [MaxW-1:0] AddressBusZero = '0;
  localparam logic [MaxW-1:0] WordZero       = '0;

  function automatic int unsigned idx_width(input int unsigned lines);
    return $clog2(lines);
  endfunction

  function automatic int unsigned tag_width(input int unsigned addr_w, input int unsigned lines);
    return addr_w - 2 - $clog2(lines);
  endfunction

endpackage

// File: rtl/i_line_buffer.sv
// Direct-mapped one-word line storage: data, tag and valid per line.
// Addresses are word addresses; flush beats a fill on the same edge.
module i_line_buffer
  import i_bus_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic [ADDR_W-3:0] rd_addr_i,
  output logic              rd_hit_o,
  output logic [DATA_W-1:0] rd_data_o,
  input  logic [ADDR_W-3:0] chk_addr_i,
  output logic              chk_hit_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-3:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i
);

  localparam int unsigned IdxW  = idx_width(LINES);
  localparam int unsigned TagW  = tag_width(ADDR_W, LINES);
  localparam int unsigned WordW = ADDR_W - 2;

  logic [DATA_W-1:0] data_q [LINES];
  logic [TagW-1:0]   tag_q  [LINES];
  logic [LINES-1:0]  valid_q, valid_d;

  logic [IdxW-1:0] rd_idx, chk_idx, wr_idx;
  logic [TagW-1:0] rd_tag, chk_tag, wr_tag;

  assign rd_idx  = rd_addr_i[IdxW-1:0];
  assign rd_tag  = rd_addr_i[WordW-1:IdxW];
  assign chk_idx = chk_addr_i[IdxW-1:0];
  assign chk_tag = chk_addr_i[WordW-1:IdxW];
  assign wr_idx  = wr_addr_i[IdxW-1:0];
  assign wr_tag  = wr_addr_i[WordW-1:IdxW];

  assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];
  assign chk_hit_o = valid_q[chk_idx] && (tag_q[chk_idx] == chk_tag);

  always_comb begin
    valid_d = valid_q;
    if (flush_i) begin
      valid_d = '0;
    end else if (wr_en_i) begin
      valid_d[wr_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
    if (wr_en_i) begin
      data_q[wr_idx] <= wr_data_i;
      tag_q[wr_idx]  <= wr_tag;
    end
  end

endmodule

// File: rtl/i_bus_prefetch.sv
// Instruction fetch buffer with a Wishbone master port.
// Define IBUS_PREFETCH_EN to fetch the next sequential line after each demand fill.
module i_bus_prefetch
  import i_bus_prefetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LINES  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] in_InstructionAddress,
  input  logic              in_Flush,
  output logic [DATA_W-1:0] Instruction,
  output logic              IWait,
  output logic              IAbort,
  output logic [ADDR_W-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [7:0]        wb_sel_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i
);

  localparam int unsigned WordW = ADDR_W - 2;

  state_e           state_q, state_d;
  logic [WordW-1:0] addr_q, addr_d;
  logic             flush_pend_q, flush_pend_d;

  logic [WordW-1:0]  req_word, next_word;
  logic              rd_hit, chk_hit, bus_active, wr_en, req_match;
  logic [DATA_W-1:0] rd_data;
  logic              unused_low;

  assign req_word   = in_InstructionAddress[ADDR_W-1:2];
  assign unused_low = ^in_InstructionAddress[1:0];
  assign next_word  = addr_q + WordW'(1);
  assign req_match  = (addr_q == req_word);

`ifdef IBUS_PREFETCH_EN
  assign bus_active = (state_q == StFetch) || (state_q == StPrefetch);
`else
  assign bus_active = (state_q == StFetch);
  logic unused_chk;
  assign unused_chk = chk_hit;
`endif

  // A flush seen mid-transfer keeps the returning word out of the buffer.
  assign wr_en = bus_active && wb_ack_i && !flush_pend_q;

  i_line_buffer #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .LINES (LINES)
  ) u_lines (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (in_Flush),
    .rd_addr_i (req_word),
    .rd_hit_o  (rd_hit),
    .rd_data_o (rd_data),
    .chk_addr_i(next_word),
    .chk_hit_o (chk_hit),
    .wr_en_i   (wr_en),
    .wr_addr_i (addr_q),
    .wr_data_i (wb_data_i)
  );

  assign wb_cyc_o  = bus_active;
  assign wb_stb_o  = bus_active;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = WB_SEL_WORD;
  assign wb_data_o = WordZero[DATA_W-1:0];
  assign wb_addr_o = {addr_q, 2'b00};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      addr_q       <= AddressBusZero[WordW-1:0];
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    flush_pend_d = flush_pend_q | in_Flush;
    unique case (state_q)
      StIdle: begin
        flush_pend_d = 1'b0;
        if (!rd_hit) begin
          state_d = StFetch;
          addr_d  = req_word;
        end
      end
      StFetch: begin
        if (wb_ack_i) begin
          state_d = StIdle;
`ifdef IBUS_PREFETCH_EN
          if (!chk_hit) begin
            state_d      = StPrefetch;
            addr_d       = next_word;
            flush_pend_d = 1'b0;
          end
`endif
        end else if (wb_err_i) begin
          state_d = StIdle;
        end else if (wb_rty_i) begin
          state_d = StRetry;
        end
      end
      StRetry: state_d = StFetch;
`ifdef IBUS_PREFETCH_EN
      StPrefetch: begin
        if (wb_ack_i || wb_err_i || wb_rty_i) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    Instruction = WordZero[DATA_W-1:0];
    IWait       = 1'b1;
    IAbort      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_hit) begin
          Instruction = rd_data;
          IWait       = 1'b0;
        end
      end
      StFetch: begin
        if (wb_ack_i && req_match) begin
          Instruction = wb_data_i;
          IWait       = 1'b0;
        end else if (!wb_ack_i && wb_err_i && req_match) begin
          IAbort = 1'b1;
          IWait  = 1'b0;
        end
      end
`ifdef IBUS_PREFETCH_EN
      StPrefetch: begin
        if (rd_hit) begin
          Instruction = rd_data;
          IWait       = 1'b0;
        end
      end
`endif
      default: IWait = 1'b1;
    endcase
    if (rst_i) begin
      Instruction = WordZero[DATA_W-1:0];
      IAbort      = 1'b0;
    end
  end

endmodule
